multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle successor to the single-cycle opcode decoder in the processor datapath. It accepts one instruction opcode at a time over a valid/ready handshake, sequences it through decode, execute, memory and write-back states, and drives the datapath strobes for each state. It also holds the compare flags, resolves conditional jumps from them, waits on a memory acknowledge with a bounded timeout, and flags illegal opcodes and bus errors.

## Interface
- OPW, 4: opcode width, minimum 4. Bits above [3:0] must be zero; any other value is illegal.
- TIMEOUT, 15: maximum number of MEM cycles to wait for mem_ack before a bus error.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  opcode is presented.
- opcode  in  OPW  instruction opcode; sampled only on handshake.
- cmp_lt  in  1  ALU "less than" result; sampled in EXEC of CMP.
- cmp_eq  in  1  ALU "equal" result; sampled in EXEC of CMP.
- mem_ack  in  1  memory completion.
- instr_ready  out  1  controller is in IDLE.
- alu_sel  out  1  ALU logic-op select (1) vs add (0).
- alu_imm  out  1  ALU B operand from immediate.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- reg_we  out  1  register-file write.
- pc_we  out  1  PC update.
- pc_src  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = register.
- illegal  out  1  sticky flag: illegal opcode.
- err  out  1  sticky flag: memory timeout.

## Operation
- Opcode map on op[3:0], written as bits {0,1,2,3}:
  - 0 ADD, 8 ADDI, 4 AND, 12 ANDI.
  - 2 LD, 10 ST, 6 CMP, 14 JMPR.
  - 1 JB, 9 JBE, 5 JA, 13 JAE.
  - Any code with op[0]=1 and op[1]=1 is JE.
- Decoded strobes:
  - alu_sel is set for AND and ANDI.
  - alu_imm is set for ADDI and ANDI.
- States:
  - IDLE: instr_ready=1. When instr_valid=1, op_q <= opcode and the FSM goes to DECODE. instr_valid is ignored in every other state.
  - DECODE: if op_q[OPW-1:4] is nonzero, go to HALT and set illegal. Otherwise go to EXEC.
  - EXEC:
    - ALU ops: alu_sel and alu_imm are driven, then go to WB.
    - CMP: flags lt_q, eq_q are loaded from cmp_lt/cmp_eq. pc_we=1, pc_src=00, then go to IDLE.
    - Jumps: pc_we=1, then go to IDLE. pc_src=01 if taken (JMPR uses 10, always taken); otherwise 00.
    - LD/ST: counter cleared, then go to MEM.
  - MEM:
    - mem_req=1, and mem_we=1 for ST.
    - On mem_ack: LD goes to WB. ST asserts pc_we=1, pc_src=00 and goes to IDLE.
    - Without ack, the counter increments. When the count reaches TIMEOUT, go to HALT and set err.
  - WB: reg_we=1, pc_we=1, pc_src=00, then go to IDLE.
  - HALT: all strobes 0 and instr_ready=0. Leaves only on rst.
- Jump conditions:
  - JB taken on lt_q.
  - JBE taken on lt_q|eq_q.
  - JA taken on !lt_q&!eq_q.
  - JAE taken on !lt_q.
  - JE taken on eq_q.
- Flags change only in EXEC of CMP.
- Counter width is clog2(TIMEOUT+1).

## Timing
- Reset:
  - On the cycle after rst is sampled high: state IDLE, instr_ready=1, every other output 0.
  - lt_q=0, eq_q=0, counter=0, op_q=0.
  - Reset mid-instruction aborts it with no further strobes.
- Strobes are Moore outputs of the registered state and op_q. Each is high for exactly the cycle(s) its state lasts.
- Handshake is accepted in cycle 0. Latencies from there:
  - ALU op: DECODE c1, EXEC c2, WB c3 (reg_we, pc_we), instr_ready again at c4.
  - CMP or jump: EXEC c2 with pc_we; IDLE at c3.
  - LD with immediate ack: MEM c3, WB c4, IDLE c5.
  - ST with immediate ack: MEM c3 with pc_we; IDLE c4.
- mem_ack is honoured in the first MEM cycle. Any mem_ack outside MEM is ignored.
- Timeout: an ack in MEM cycle TIMEOUT (count = TIMEOUT-1 at entry) completes normally. No ack through TIMEOUT MEM cycles means HALT on the next edge.
- Back-to-back: the next instr_valid is accepted in the first IDLE cycle.

## Test plan
- Reset, then ADDI (opcode 8) -> instr_ready drops at c1. At c3: reg_we=1, alu_imm=1, alu_sel=0, pc_we=1, pc_src=00. instr_ready=1 at c4.
- CMP with cmp_lt=1, cmp_eq=0, then JB (1), then JA (5) -> JB: pc_src=01. JA: pc_src=00. Then CMP with eq=1 followed by JE (3) -> pc_src=01.
- JMPR (14) directly after reset -> EXEC pc_we=1, pc_src=10. Separately, JA after reset -> taken (flags 0).
- LD (2) with mem_ack delayed 3 cycles -> mem_req high for 4 cycles, mem_we=0, then reg_we for 1 cycle. ST (10) with ack in the first MEM cycle -> mem_req=mem_we=1 for 1 cycle, plus pc_we.
- TIMEOUT=4, LD with no ack -> mem_req high 4 cycles, then err=1, instr_ready=0 held. rst clears it. Ack arriving on the 4th cycle -> normal completion.
- OPW=6, opcode 6'b010000 -> illegal=1 after DECODE, no strobes. Also: rst asserted during MEM -> IDLE next cycle, mem_req=0.

Source files
------------

// File: rtl/multi_cycle_control_if.sv
// Opcode handshake, compare flags, memory handshake and datapath strobes
// between the multi-cycle controller (slave) and its surrounding datapath (master).
interface multi_cycle_control_if #(
  parameter int OPW = 4
);
  logic           instr_valid;
  logic [OPW-1:0] opcode;
  logic           instr_ready;
  logic           cmp_lt;
  logic           cmp_eq;
  logic           mem_ack;
  logic           alu_sel;
  logic           alu_imm;
  logic           mem_req;
  logic           mem_we;
  logic           reg_we;
  logic           pc_we;
  logic [1:0]     pc_src;
  logic           illegal;
  logic           err;

  modport master (
    output instr_valid, opcode, cmp_lt, cmp_eq, mem_ack,
    input  instr_ready, alu_sel, alu_imm, mem_req, mem_we, reg_we, pc_we,
           pc_src, illegal, err
  );

  modport slave (
    input  instr_valid, opcode, cmp_lt, cmp_eq, mem_ack,
    output instr_ready, alu_sel, alu_imm, mem_req, mem_we, reg_we, pc_we,
           pc_src, illegal, err
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle instruction controller: IDLE -> DECODE -> EXEC -> (MEM) -> (WB),
// holding compare flags, resolving conditional jumps and bounding memory waits.
module multi_cycle_control #(
  parameter int OPW     = 4,
  parameter int TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst,
  multi_cycle_control_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t         state, state_nxt;
  logic [OPW-1:0] op_q;
  logic           lt_q, eq_q;
  logic [CNT_W-1:0] cnt;
  logic           illegal_q, err_q;

  logic [3:0] op;
  logic       upper_nz, is_alu, is_ld, is_st, is_cmp, is_jmpr, taken, timeout_hit;
  logic       instr_ready, alu_sel, alu_imm, mem_req, mem_we, reg_we, pc_we;
  logic [1:0] pc_src;

  assign op          = op_q[3:0];
  assign upper_nz    = (op_q & ~OPW'(4'hF)) != '0;
  assign is_alu      = !op[0] && !op[1];
  assign is_ld       = op == 4'd2;
  assign is_st       = op == 4'd10;
  assign is_cmp      = op == 4'd6;
  assign is_jmpr     = op == 4'd14;
  assign timeout_hit = cnt == CNT_W'(TIMEOUT - 1);

  // Odd opcodes are conditional jumps; op[1] selects JE, op[3:2] the lt/eq test.
  always_comb begin
    taken = 1'b0;
    if (op[1]) begin
      taken = eq_q;
    end else begin
      case (op[3:2])
        2'b00:   taken = lt_q;
        2'b10:   taken = lt_q | eq_q;
        2'b01:   taken = !lt_q && !eq_q;
        default: taken = !lt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      cnt       <= '0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.instr_valid) op_q <= bus.opcode;
      if (state == EXEC && is_cmp) begin
        lt_q <= bus.cmp_lt;
        eq_q <= bus.cmp_eq;
      end
      if (state == EXEC) cnt <= '0;
      else if (state == MEM && !bus.mem_ack) cnt <= cnt + 1'b1;
      if (state == DECODE && upper_nz) illegal_q <= 1'b1;
      if (state == MEM && !bus.mem_ack && timeout_hit) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    alu_sel     = 1'b0;
    alu_imm     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'b00;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) state_nxt = DECODE;
      end
      DECODE: state_nxt = upper_nz ? HALT : EXEC;
      EXEC: begin
        if (is_alu) begin
          alu_sel   = op[2];
          alu_imm   = op[3];
          state_nxt = WB;
        end else if (is_ld || is_st) begin
          state_nxt = MEM;
        end else begin
          pc_we     = 1'b1;
          state_nxt = IDLE;
          if (is_jmpr)     pc_src = 2'b10;
          else if (op[0])  pc_src = taken ? 2'b01 : 2'b00;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_st;
        // A store retires in its ack cycle; a load still needs write-back.
        if (bus.mem_ack) begin
          if (is_st) begin
            pc_we     = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WB;
          end
        end else if (timeout_hit) begin
          state_nxt = HALT;
        end
      end
      WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        alu_sel   = is_alu && op[2];
        alu_imm   = is_alu && op[3];
        state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.instr_ready = instr_ready;
  assign bus.alu_sel     = alu_sel;
  assign bus.alu_imm     = alu_imm;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.reg_we      = reg_we;
  assign bus.pc_we       = pc_we;
  assign bus.pc_src      = pc_src;
  assign bus.illegal     = illegal_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed and random instructions checked
// cycle by cycle against an instruction-level reference model.
module tb_multi_cycle_control;
  localparam int OPW     = 6;
  localparam int TIMEOUT = 4;

  // Output vector: {ready, sel, imm, req, mwe, rwe, pcwe, src[1:0], ill, err}
  localparam logic [10:0] R      = 11'h400;
  localparam logic [10:0] SEL    = 11'h200;
  localparam logic [10:0] IMM    = 11'h100;
  localparam logic [10:0] REQ    = 11'h080;
  localparam logic [10:0] MWE    = 11'h040;
  localparam logic [10:0] RWE    = 11'h020;
  localparam logic [10:0] PCWE   = 11'h010;
  localparam logic [10:0] SRC_BR = 11'h004;
  localparam logic [10:0] SRC_RG = 11'h008;
  localparam logic [10:0] ILL    = 11'h002;
  localparam logic [10:0] ERR    = 11'h001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   m_lt, m_eq, halted;

  always #5 clk = ~clk;

  multi_cycle_control_if #(.OPW(OPW)) bus ();

  multi_cycle_control #(.OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [10:0] outs();
    return {bus.instr_ready, bus.alu_sel, bus.alu_imm, bus.mem_req, bus.mem_we,
            bus.reg_we, bus.pc_we, bus.pc_src, bus.illegal, bus.err};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance past the edge.
  task automatic cycle(input bit vld, input logic [OPW-1:0] opc, input bit ack,
                       input bit lt, input bit eq, input logic [10:0] exp,
                       input string tag);
    logic [10:0] got;
    bus.instr_valid = vld;
    bus.opcode      = opc;
    bus.mem_ack     = ack;
    bus.cmp_lt      = lt;
    bus.cmp_eq      = eq;
    @(negedge clk);
    got = outs();
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.mem_ack     = 1'b0;
  endtask

  // Cycle with random noise on every input the current state must ignore.
  task automatic ncycle(input logic [10:0] exp, input string tag);
    cycle(rb(), OPW'($urandom), rb(), rb(), rb(), exp, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.mem_ack     = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_lt   = 1'b0;
    m_eq   = 1'b0;
    halted = 1'b0;
  endtask

  // Issue one instruction from IDLE and check every cycle until it retires or halts.
  task automatic do_instr(input logic [OPW-1:0] opc, input int ack_dly,
                          input bit cl, input bit ce);
    logic [3:0]  lo;
    logic [10:0] e, src;
    bit          st, tk;
    lo = opc[3:0];
    cycle(1'b1, opc, rb(), rb(), rb(), R, "idle_accept");
    ncycle('0, "decode");
    if (opc[OPW-1:4] != '0) begin
      repeat (3) ncycle(ILL, "halt_illegal");
      halted = 1'b1;
      return;
    end
    case (lo)
      4'd0, 4'd4, 4'd8, 4'd12: begin
        e = ((lo == 4'd4 || lo == 4'd12) ? SEL : '0) |
            ((lo == 4'd8 || lo == 4'd12) ? IMM : '0);
        ncycle(e, "exec_alu");
        ncycle(e | RWE | PCWE, "wb_alu");
      end
      4'd6: begin
        cycle(rb(), OPW'($urandom), rb(), cl, ce, PCWE, "exec_cmp");
        m_lt = cl;
        m_eq = ce;
      end
      4'd2, 4'd10: begin
        st = (lo == 4'd10);
        ncycle('0, "exec_mem");
        for (int k = 0; k < TIMEOUT; k++) begin
          if (k == ack_dly) begin
            cycle(rb(), OPW'($urandom), 1'b1, rb(), rb(),
                  REQ | (st ? (MWE | PCWE) : '0), "mem_ack");
            if (!st) ncycle(RWE | PCWE, "wb_ld");
            return;
          end
          cycle(rb(), OPW'($urandom), 1'b0, rb(), rb(), REQ | (st ? MWE : '0),
                "mem_wait");
        end
        repeat (3) ncycle(ERR, "halt_timeout");
        halted = 1'b1;
      end
      default: begin
        case (lo)
          4'd14:   tk = 1'b1;
          4'd1:    tk = m_lt;
          4'd9:    tk = m_lt || m_eq;
          4'd5:    tk = !m_lt && !m_eq;
          4'd13:   tk = !m_lt;
          default: tk = m_eq;
        endcase
        src = (lo == 4'd14) ? SRC_RG : (tk ? SRC_BR : '0);
        ncycle(PCWE | src, "exec_jump");
      end
    endcase
  endtask

  initial begin
    logic [OPW-1:0] rop;
    bus.instr_valid = 1'b0;
    bus.opcode      = '0;
    bus.mem_ack     = 1'b0;
    bus.cmp_lt      = 1'b0;
    bus.cmp_eq      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, R, "reset_state");

    do_instr(6'd8, 0, 0, 0);   // ADDI
    do_instr(6'd12, 0, 0, 0);  // ANDI
    do_instr(6'd4, 0, 0, 0);   // AND
    do_instr(6'd6, 0, 1, 0);   // CMP lt
    do_instr(6'd1, 0, 0, 0);   // JB taken
    do_instr(6'd5, 0, 0, 0);   // JA not taken
    do_instr(6'd6, 0, 0, 1);   // CMP eq
    do_instr(6'd3, 0, 0, 0);   // JE taken
    do_instr(6'd9, 0, 0, 0);   // JBE taken
    do_instr(6'd13, 0, 0, 0);  // JAE taken

    do_reset();
    do_instr(6'd14, 0, 0, 0);  // JMPR
    do_reset();
    do_instr(6'd5, 0, 0, 0);   // JA with cleared flags
    do_instr(6'd2, 3, 0, 0);   // LD, ack in 4th MEM cycle
    do_instr(6'd10, 0, 0, 0);  // ST, immediate ack
    do_instr(6'd2, 99, 0, 0);  // LD timeout
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, R, "reset_after_halt");
    do_instr(6'd10, 3, 0, 0);  // ST, ack in last allowed cycle
    do_instr(6'b010000, 0, 0, 0);
    do_reset();

    // Reset while waiting in MEM aborts the load.
    cycle(1'b1, 6'd2, 1'b0, rb(), rb(), R, "mr_accept");
    ncycle('0, "mr_decode");
    ncycle('0, "mr_exec");
    cycle(1'b0, '0, 1'b0, rb(), rb(), REQ, "mr_mem");
    do_reset();
    cycle(1'b0, '0, 1'b1, rb(), rb(), R, "mr_after_reset");
    do_instr(6'd0, 0, 0, 0);   // ADD

    for (int n = 0; n < 200; n++) begin
      rop = {2'b00, 4'($urandom)};
      if ($urandom_range(0, 9) == 0) rop[OPW-1:4] = 2'($urandom_range(1, 3));
      do_instr(rop, int'($urandom_range(0, TIMEOUT + 1)), rb(), rb());
      if (halted) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
